// File: rtl/alarm_buzz.sv
// Alarm stage: compares synchronised min/sec time to the alarm time, rings a square-wave buzzer with stop/snooze/timeout.
// Latency: input time change -> t after 3 edges -> RINGING on the 4th edge; buzz/ringing registered.
// Backpressure: none; stop/snooze are single-clk pulses, optional beep gating via `ALARM_BEEP_EN`.
module alarm_buzz #(
    parameter int TONE_DIV   = 50000,
    parameter int BEEP_DIV   = 25000000,
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [5:0] i_alarm_sec,
    input  logic [5:0] i_alarm_min,
    input  logic       i_alarm_en,
    input  logic       i_stop,
    input  logic       i_snooze,
    output logic       o_buzz,
    output logic       o_ringing,
    output logic [1:0] o_state
);

    localparam int HALF = TONE_DIV / 2;
    localparam int TW   = $clog2(HALF + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
    } mmss_t;

    // Elaboration-time guard against unusable parameter values.
    if (TONE_DIV < 2 || (TONE_DIV % 2) != 0 || BEEP_DIV < 1 ||
        RING_SEC < 1 || RING_SEC > 63 || SNOOZE_SEC < 1 || SNOOZE_SEC > 511) begin : g_param_err
        $error("alarm_buzz: parameter out of range");
    end

    mmss_t       s1, s2, t;
    logic [5:0]  sec_prev;
    logic        match, match_d, trig, tick;
    state_t      state;
    logic [5:0]  ring_cnt;
    logic [8:0]  snz_cnt;
    logic [TW-1:0] tone_cnt;
    logic        tone, tone_wrap, tone_adv, gate_adv;

`ifdef ALARM_BEEP_EN
    localparam int BW = $clog2(BEEP_DIV + 1);
    logic [BW-1:0] beep_cnt;
    logic          gate, beep_wrap;
`endif

    // Two-stage sampling of the counter time; t only follows s2 once two samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            t        <= '0;
            sec_prev <= '0;
            match_d  <= 1'b1;
        end else begin
            s1       <= {i_min, i_sec};
            s2       <= s1;
            if (s1 == s2) t <= s2;
            sec_prev <= t.sec;
            match_d  <= match;
        end
    end

    // Match edge, second tick and next tone/gate levels.
    always_comb begin
        match     = (t == {i_alarm_min, i_alarm_sec});
        trig      = match & ~match_d;
        tick      = (t.sec != sec_prev);
        tone_wrap = (tone_cnt == TW'(HALF - 1));
        tone_adv  = tone ^ tone_wrap;
`ifdef ALARM_BEEP_EN
        beep_wrap = (beep_cnt == BW'(BEEP_DIV - 1));
        gate_adv  = gate ^ beep_wrap;
`else
        gate_adv  = 1'b1;
`endif
    end

    // Alarm state machine; tone/beep machinery is cleared whenever RINGING is not held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ring_cnt  <= '0;
            snz_cnt   <= '0;
            tone_cnt  <= '0;
            tone      <= 1'b0;
            o_buzz    <= 1'b0;
            o_ringing <= 1'b0;
`ifdef ALARM_BEEP_EN
            beep_cnt  <= '0;
            gate      <= 1'b1;
`endif
        end else begin
            o_buzz    <= 1'b0;
            o_ringing <= 1'b0;
            tone_cnt  <= '0;
            tone      <= 1'b0;
`ifdef ALARM_BEEP_EN
            beep_cnt  <= '0;
            gate      <= 1'b1;
`endif
            if (!i_alarm_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= ARMED;
                    ARMED: begin
                        if (trig) begin
                            state     <= RINGING;
                            ring_cnt  <= 6'(RING_SEC);
                            o_ringing <= 1'b1;
                        end
                    end
                    RINGING: begin
                        if (i_stop) begin
                            state <= ARMED;
                        end else if (i_snooze) begin
                            state   <= SNOOZE;
                            snz_cnt <= 9'(SNOOZE_SEC);
                        end else if (tick && ring_cnt == 6'd1) begin
                            state <= ARMED;
                        end else begin
                            if (tick) ring_cnt <= ring_cnt - 6'd1;
                            o_ringing <= 1'b1;
                            tone_cnt  <= tone_wrap ? '0 : tone_cnt + TW'(1);
                            tone      <= tone_adv;
                            o_buzz    <= tone_adv & gate_adv;
`ifdef ALARM_BEEP_EN
                            beep_cnt  <= beep_wrap ? '0 : beep_cnt + BW'(1);
                            gate      <= gate_adv;
`endif
                        end
                    end
                    SNOOZE: begin
                        if (i_stop) begin
                            state <= ARMED;
                        end else if (tick) begin
                            if (snz_cnt == 9'd1) begin
                                state     <= RINGING;
                                ring_cnt  <= 6'(RING_SEC);
                                o_ringing <= 1'b1;
                            end else begin
                                snz_cnt <= snz_cnt - 9'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_state = state;

endmodule

// File: doc/alarm_buzz.md
# alarm_buzz

Alarm stage downstream of the min/sec counter. Consumes the running `o_min`/`o_sec` values produced by `minsec`, compares them against a user alarm time, and drives a piezo buzzer output with a square-wave tone. Supports stop, snooze and automatic ring timeout. Sits beside `led_disp` in `top_hms_clock`.

## Interface
- `TONE_DIV`, 50000, clk cycles per tone period; 1 kHz at 50 MHz; even, ≥2
- `BEEP_DIV`, 25000000, clk cycles per beep half-period; used only with `ALARM_BEEP_EN`
- `RING_SEC`, 30, second ticks before an unacknowledged ring times out; 1..63
- `SNOOZE_SEC`, 300, second ticks spent in snooze; 1..511
- `clk` in 1: 50 MHz system clock
- `rst_n` in 1: asynchronous, active-low reset
- `i_sec` in 6: current seconds 0..59, from `minsec`
- `i_min` in 6: current minutes 0..59, from `minsec`
- `i_alarm_sec` in 6: alarm seconds, level, 0..59
- `i_alarm_min` in 6: alarm minutes, level, 0..59
- `i_alarm_en` in 1: level; 1 = alarm armed
- `i_stop` in 1: one-clk pulse, already debounced; acknowledges the alarm
- `i_snooze` in 1: one-clk pulse, already debounced; snoozes the alarm
- `o_buzz` out 1: buzzer drive, registered
- `o_ringing` out 1: 1 while in RINGING, registered
- `o_state` out 2: state encoding: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3

## Operation
- **Input sync.** `{i_min,i_sec}` passes through two register stages (s1, s2). The sampled time `t` updates from s2 only when s1==s2; otherwise `t` holds. This filters changes that cross from the `sec_clk` domain.
- **Second tick.** A one-clk pulse fires whenever `t.sec` differs from its previous value. Jumps made in SETUP mode also count as ticks.
- **Match.** `match = (t == {i_alarm_min,i_alarm_sec})`. A registered `match_d` gives the trigger `match & ~match_d`. `match_d` resets to 1, so reset at 00:00 with the alarm set to 00:00 does not ring.
- **IDLE.** `o_buzz`=0. Goes to ARMED when `i_alarm_en`=1.
- **ARMED.** Goes to RINGING on trigger; the ring counter loads `RING_SEC` and the tone counter clears.
- **RINGING.**
  - `o_buzz` toggles every `TONE_DIV/2` clks.
  - The ring counter decrements on each tick; on reaching 0, go to ARMED.
  - `i_stop` → ARMED.
  - `i_snooze` → SNOOZE, with the snooze counter loaded to `SNOOZE_SEC`.
- **SNOOZE.** `o_buzz`=0. The snooze counter decrements on each tick; on reaching 0, go to RINGING with the ring counter reloaded. `i_stop` → ARMED.
- **Priorities.**
  - `i_alarm_en`=0 in any state → IDLE on the next edge; this has highest priority.
  - Then `i_stop`, then `i_snooze`, then timeout/tick.
  - `i_stop` and `i_snooze` in the same cycle → stop wins.
- **Retriggering.** After stop or timeout, re-ringing needs a new match edge. Holding the time at the alarm value (e.g. setup mode) does not retrigger.
- **Reset values.** All counters and state are 0. `o_buzz`=0, `o_ringing`=0, `o_state`=IDLE, s1/s2/`t`=0, `match_d`=1.

## Timing
- Change on `i_sec`/`i_min` → `t` updated on the 3rd clk edge.
- Trigger is combinational from `t`. `o_state`/`o_ringing` = RINGING one edge after `t` matches, i.e. 4 edges after the input change.
- On entering RINGING, `o_buzz`=0 and the tone counter=0. First `o_buzz` rise occurs `TONE_DIV/2` clks after entry.
- Leaving RINGING for any reason: `o_buzz`=0 and `o_ringing`=0 on the same edge as the state change.
- A tick and `i_stop` in the same cycle: stop wins; the counter is not decremented.
- Timeout takes exactly `RING_SEC` ticks after entry.
- `rst_n` asserted mid-ring: `o_buzz`/`o_ringing` clear immediately (asynchronously).

## Configuration
- `ALARM_BEEP_EN` defined:
  - A beep counter runs while RINGING and toggles a gate every `BEEP_DIV` clks.
  - `o_buzz` = tone AND gate.
  - The gate starts at 1 on entry to RINGING, giving a 1 Hz on/off pattern at defaults.
- `ALARM_BEEP_EN` undefined: continuous tone while RINGING; no beep counter is synthesised.

## Test plan
Benches use `TONE_DIV`=10, `BEEP_DIV`=40, `RING_SEC`=3, `SNOOZE_SEC`=2.
- **Ring + timeout.** Alarm 01:05, en=1; step time 01:04→01:05.
  - `o_state`=2 four clks after the change.
  - `o_buzz` period is 10 clks.
  - Back to 1 after 3 sec ticks.
- **Stop and no retrigger.** While ringing, pulse `i_stop` → state 1, buzz 0 next edge. Hold time at 01:05 for 100 clks → no re-ring.
- **Snooze cycle.** Ring; pulse `i_snooze` → state 3, buzz 0. After 2 sec ticks → state 2 again, ring counter=3.
- **Simultaneous stop+snooze.** While ringing, assert both in one clk → state 1.
- **Disable/reset.** Drop `i_alarm_en` mid-ring → state 0 next edge. Separately, assert `rst_n`=0 mid-ring → outputs 0 immediately. Reset with time 00:00 and alarm 00:00 → no ring.
- **Beep gate.** With `ALARM_BEEP_EN` defined, ring → tone present for 40 clks, silent for 40, repeating. Without the macro → continuous tone.
